uart_rx_fifo: RTL

//  Receive-side byte buffer between uart_receive and ctrl. Accepts each byte uart_receive completes,

---
 rtl/uart_rx_fifo_pkg.sv | 20 ++
 rtl/uart_fifo_mem.sv | 24 ++
 rtl/uart_rx_fifo.sv | 129 ++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_pkg.sv
// Shared types and defaults for the UART receive-side byte buffer.
package uart_rx_fifo_pkg;

  localparam int DEF_DEPTH        = 16;
  localparam int DEF_DATA_W       = 8;
  localparam int DEF_TIMEOUT_BITS = 40;

  typedef enum logic {
    ACK_IDLE = 1'b0,
    ACK_HOLD = 1'b1
  } ack_state_t;

  // Idle limit in clk cycles; the product is assumed to fit in 32 bits.
  function automatic logic [31:0] tmo_limit(input int unsigned bits, input logic [31:0] div);
    logic [31:0] b;
    b = 32'(bits);
    return b * div;
  endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x WIDTH storage array: one synchronous write port, asynchronous read.
// Storage is deliberately unreset; validity is tracked by the caller's count.
module uart_fifo_mem #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 9,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Show-ahead RX byte FIFO with 4-phase ack, threshold and char-timeout IRQs; head visible 1 cycle after push.
// Never backpressures the receiver: bytes arriving while full are acked, dropped and flagged as overflow.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DEPTH        = DEF_DEPTH,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int TIMEOUT_BITS = DEF_TIMEOUT_BITS,
  localparam int AW          = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       clk_div,
  input  logic              i_byte_valid,
  input  logic [DATA_W-1:0] i_rx_data,
  input  logic              i_frame_err,
  output logic              o_byte_ack,
  output logic [DATA_W:0]   o_rd_data,
  output logic              o_rd_valid,
  input  logic              i_rd_pop,
  input  logic              i_flush,
  input  logic [AW:0]       i_thresh,
  output logic [AW:0]       o_count,
  output logic              o_overflow,
  input  logic              i_ovf_clear,
  output logic              o_irq_thresh,
  output logic              o_irq_timeout
);

  ack_state_t      ack_state;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count, count_next;
  logic [31:0]     tmo_cnt, tmo_next, limit;
  logic            push_req, full, empty, do_push, do_pop, ovf_evt;
  logic [DATA_W:0] head;

  assign push_req = (ack_state == ACK_IDLE) && i_byte_valid;
  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = i_rd_pop && !empty && !i_flush;
  // A same-cycle pop frees a slot, so a push into a full FIFO still lands.
  assign do_push  = push_req && !i_flush && (!full || do_pop);
  assign ovf_evt  = push_req && !i_flush && full && !do_pop;
  assign limit    = tmo_limit(TIMEOUT_BITS, clk_div);

  always_comb begin
    count_next = count;
    if (i_flush) begin
      count_next = '0;
    end else begin
      case ({do_push, do_pop})
        2'b10:   count_next = count + (AW+1)'(1);
        2'b01:   count_next = count - (AW+1)'(1);
        default: count_next = count;
      endcase
    end
  end

  always_comb begin
    tmo_next = tmo_cnt;
    if (do_push || do_pop || i_flush || empty) tmo_next = '0;
    else if (tmo_cnt < limit)                  tmo_next = tmo_cnt + 32'd1;
  end

  uart_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_W + 1)
  ) u_mem (
    .clk   (clk),
    .we    (do_push),
    .waddr (wr_ptr),
    .wdata ({i_frame_err, i_rx_data}),
    .raddr (rd_ptr),
    .rdata (head)
  );

  assign o_rd_valid = !empty;
  assign o_rd_data  = empty ? '0 : head;
  assign o_count    = count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_state  <= ACK_IDLE;
      o_byte_ack <= 1'b0;
    end else begin
      case (ack_state)
        ACK_IDLE: if (i_byte_valid) begin
          ack_state  <= ACK_HOLD;
          o_byte_ack <= 1'b1;
        end
        ACK_HOLD: if (!i_byte_valid) begin
          ack_state  <= ACK_IDLE;
          o_byte_ack <= 1'b0;
        end
        default: begin
          ack_state  <= ACK_IDLE;
          o_byte_ack <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      tmo_cnt       <= '0;
      o_overflow    <= 1'b0;
      o_irq_thresh  <= 1'b0;
      o_irq_timeout <= 1'b0;
    end else begin
      if (i_flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + AW'(1);
        if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      end
      count         <= count_next;
      tmo_cnt       <= tmo_next;
      o_irq_timeout <= (limit != '0) && (tmo_next == limit);
      o_irq_thresh  <= (i_thresh != '0) && (count_next >= i_thresh);
      if (ovf_evt)          o_overflow <= 1'b1;
      else if (i_ovf_clear) o_overflow <= 1'b0;
    end
  end

endmodule
